// File: rtl/simon_arb_pkg.sv
// Shared types and constants for the SIMON 96/144 core arbiter.
package simon_arb_pkg;
  localparam int SIMON96_N = 48;
  localparam int SIMON96_M = 3;
  localparam int ARB_R     = 2;

  typedef enum logic [2:0] {
    IDLE, GRANT, KEY_REQ, KEY_WAIT, DATA_REQ, DATA_WAIT, RESP
  } arb_state_t;
endpackage

// File: rtl/simon_rr_pick.sv
// Two-way round-robin winner select; the pointer flips away from each accepted winner.
module simon_rr_pick (
  input  logic       clk,
  input  logic       nR,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic       o_any,
  output logic       o_winner
);
  logic r_ptr;

  always_comb begin
    o_any    = |i_valid;
    o_winner = i_valid[r_ptr] ? r_ptr : ~r_ptr;
  end

  always_ff @(posedge clk) begin
    if (nR)            r_ptr <= 1'b0;
    else if (i_accept) r_ptr <= ~o_winner;
  end
endmodule

// File: rtl/simon_core_arbiter.sv
// Shares one SIMON 96/144 core between two requesters, one block in flight,
// reloading the core key only when the granted requester's key is not already loaded.
module simon_core_arbiter
  import simon_arb_pkg::*;
#(
  parameter int N = SIMON96_N,
  parameter int M = SIMON96_M,
  parameter int R = ARB_R
) (
  input  logic                       clk,
  input  logic                       nR,
  input  logic [R-1:0]               req_valid,
  output logic [R-1:0]               req_ready,
  input  logic [R-1:0]               req_enc_dec,
  input  logic [R-1:0]               req_key_upd,
  input  logic [R-1:0][1:0][N-1:0]   req_data,
  input  logic [R-1:0][M-1:0][N-1:0] req_key,
  output logic [R-1:0]               rsp_valid,
  input  logic [R-1:0]               rsp_ready,
  output logic [1:0][N-1:0]          rsp_data,
  output logic                       core_newData,
  output logic                       core_newKey,
  output logic                       core_enc_dec,
  output logic                       core_readData,
  output logic [1:0][N-1:0]          core_inData,
  output logic [M-1:0][N-1:0]        core_key,
  input  logic                       core_loadData,
  input  logic                       core_loadKey,
  input  logic                       core_doneData,
  input  logic                       core_doneKey,
  input  logic [1:0][N-1:0]          core_outData,
  output logic                       owner,
  output logic                       busy
);
  arb_state_t            r_state;
  logic                  r_owner;
  logic [1:0][N-1:0]     r_data;
  logic [M-1:0][N-1:0]   r_key;
  logic                  r_enc;
  logic                  r_upd;
  logic                  r_key_owner;
  logic                  r_key_owner_vld;
  logic [R-1:0]          r_rsp_valid;
  logic [1:0][N-1:0]     r_rsp_data;

  logic w_any, w_winner, w_accept;

  assign w_accept = (r_state == IDLE) && w_any;

  simon_rr_pick u_pick (
    .clk      (clk),
    .nR       (nR),
    .i_valid  (req_valid),
    .i_accept (w_accept),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_winner] = 1'b1;
  end

  // Core pulses are one cycle long because each one coincides with leaving its state.
  assign core_newKey   = (r_state == KEY_REQ)  && core_loadKey;
  assign core_newData  = (r_state == DATA_REQ) && core_loadData;
  assign core_readData = (r_state == RESP)     && rsp_ready[r_owner];
  assign core_inData   = r_data;
  assign core_key      = r_key;
  assign core_enc_dec  = r_enc;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign owner         = r_owner;
  assign busy          = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (nR) begin
      r_state         <= IDLE;
      r_owner         <= 1'b0;
      r_data          <= '0;
      r_key           <= '0;
      r_enc           <= 1'b0;
      r_upd           <= 1'b0;
      r_key_owner     <= 1'b0;
      r_key_owner_vld <= 1'b0;
      r_rsp_valid     <= '0;
      r_rsp_data      <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_owner <= w_winner;
          r_data  <= req_data[w_winner];
          r_key   <= req_key[w_winner];
          r_enc   <= req_enc_dec[w_winner];
          r_upd   <= req_key_upd[w_winner];
          r_state <= GRANT;
        end
        GRANT:
          r_state <= (!r_key_owner_vld || (r_key_owner != r_owner) || r_upd)
                     ? KEY_REQ : DATA_REQ;
        KEY_REQ: if (core_loadKey) r_state <= KEY_WAIT;
        KEY_WAIT: if (core_doneKey) begin
          r_key_owner     <= r_owner;
          r_key_owner_vld <= 1'b1;
          r_state         <= DATA_REQ;
        end
        DATA_REQ: if (core_loadData) r_state <= DATA_WAIT;
        DATA_WAIT: if (core_doneData) begin
          r_rsp_data           <= core_outData;
          r_rsp_valid[r_owner] <= 1'b1;
          r_state              <= RESP;
        end
        RESP: if (rsp_ready[r_owner]) begin
          r_rsp_valid <= '0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_simon_core_arbiter.sv
// Directed bench for simon_core_arbiter with a fixed-latency stand-in cipher core.
module tb_simon_core_arbiter;
  localparam int N   = 48;
  localparam int LAT = 20;
  typedef logic [1:0][N-1:0] blk_t;
  typedef logic [2:0][N-1:0] key_t;

  logic              clk = 1'b0;
  logic              nR;
  logic [1:0]        req_valid, req_ready, req_enc_dec, req_key_upd;
  logic [1:0]        rsp_valid, rsp_ready;
  logic [1:0][1:0][N-1:0] req_data;
  logic [1:0][2:0][N-1:0] req_key;
  blk_t              rsp_data, core_inData, core_outData;
  key_t              core_key;
  logic core_newData, core_newKey, core_enc_dec, core_readData;
  logic core_loadData, core_loadKey, core_doneData, core_doneKey;
  logic owner, busy;

  int total = 0;
  int bad   = 0;
  int cnt_nk = 0, cnt_nd = 0, cnt_rd = 0, cnt_ovl = 0;

  always #5 clk = ~clk;

  simon_core_arbiter dut (
    .clk(clk), .nR(nR),
    .req_valid(req_valid), .req_ready(req_ready), .req_enc_dec(req_enc_dec),
    .req_key_upd(req_key_upd), .req_data(req_data), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .core_newData(core_newData), .core_newKey(core_newKey), .core_enc_dec(core_enc_dec),
    .core_readData(core_readData), .core_inData(core_inData), .core_key(core_key),
    .core_loadData(core_loadData), .core_loadKey(core_loadKey),
    .core_doneData(core_doneData), .core_doneKey(core_doneKey),
    .core_outData(core_outData), .owner(owner), .busy(busy)
  );

  // Stand-in cipher: depends on key, block and direction so a stale key shows up.
  function automatic blk_t cipher(input key_t k, input blk_t p, input logic enc);
    blk_t c;
    c[1] = p[1] ^ k[2] ^ (enc ? k[0] : ~k[0]);
    c[0] = p[0] ^ k[1] ^ {k[2][23:0], k[0][47:24]};
    return c;
  endfunction

  key_t m_key;
  blk_t m_in;
  logic m_enc, m_kdone, m_ddone;
  int   m_cnt;

  assign core_doneKey  = m_kdone;
  assign core_doneData = m_ddone;
  assign core_outData  = m_ddone ? cipher(m_key, m_in, m_enc) : '0;
  assign core_loadData = (m_cnt == 0) && !m_ddone;
  assign core_loadKey  = (m_cnt == 0) && !m_ddone;

  always @(posedge clk) begin
    if (nR) begin
      m_kdone <= 1'b0; m_ddone <= 1'b0; m_cnt <= 0;
      m_key <= '0; m_in <= '0; m_enc <= 1'b0;
    end else begin
      m_kdone <= core_newKey;
      if (core_newKey) m_key <= core_key;
      if (core_newData) begin
        m_in <= core_inData; m_enc <= core_enc_dec; m_cnt <= LAT;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_ddone <= 1'b1;
      end
      if (core_readData) m_ddone <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (core_newKey)   cnt_nk <= cnt_nk + 1;
    if (core_newData)  cnt_nd <= cnt_nd + 1;
    if (core_readData) cnt_rd <= cnt_rd + 1;
    if ((int'(core_newKey) + int'(core_newData) + int'(core_readData)) > 1)
      cnt_ovl <= cnt_ovl + 1;
  end

  localparam key_t K0 = {48'h151413121110, 48'h0d0c0b0a0908, 48'h050403020100};
  localparam key_t K1 = {48'hA5A5A5A5A5A5, 48'h123456789ABC, 48'hFEDCBA987654};
  localparam blk_t P0 = {48'h726963696d6f, 48'h6c6c6574206e};
  localparam blk_t P1 = {48'h0123456789ab, 48'hcdef01234567};
  localparam blk_t P2 = {48'hdeadbeef0001, 48'h0000cafef00d};
  localparam blk_t P3 = {48'h111122223333, 48'h444455556666};

  task automatic do_reset();
    @(posedge clk); #1;
    nR = 1'b1; req_valid = '0; rsp_ready = '0;
    @(posedge clk); #1;
    nR = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (rsp_valid == 2'b00 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic ack(input int who);
    rsp_ready = '0; rsp_ready[who] = 1'b1;
    @(posedge clk); #1;
    rsp_ready = '0;
  endtask

  // Runs one block end to end and reports what was observed; comparisons live in the tests.
  task automatic do_block(input int who, input logic enc, input logic upd, input blk_t d,
                          input key_t k, input int hold, output logic [1:0] rdy,
                          output int lat, output logic [1:0] rv, output blk_t rd,
                          output int nk, output int nd, output int nr, output logic held_ok);
    int nk0, nd0, nr0;
    nk0 = cnt_nk; nd0 = cnt_nd; nr0 = cnt_rd;
    req_valid[who] = 1'b1; req_enc_dec[who] = enc; req_key_upd[who] = upd;
    req_data[who] = d; req_key[who] = k;
    #1 rdy = req_ready;
    @(posedge clk); #1;
    req_valid[who] = 1'b0;
    wait_rsp(lat);
    rv = rsp_valid; rd = rsp_data;
    held_ok = 1'b1;
    if (hold > 0) begin
      req_valid[1-who] = 1'b1;
      rsp_ready[1-who] = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (rsp_valid !== rv || core_readData || req_ready !== 2'b00 || rsp_data !== rd)
          held_ok = 1'b0;
      end
    end
    ack(who);
    req_valid[1-who] = 1'b0;
    nk = cnt_nk - nk0; nd = cnt_nd - nd0; nr = cnt_rd - nr0;
  endtask

  int first_lat;

  task automatic test_reset();
    do_reset();
    total++; if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", busy); bad++; end
    total++; if ({req_ready, rsp_valid, owner} !== 5'b0) begin
      $display("FAIL reset_handshake got=%b exp=0", {req_ready, rsp_valid, owner}); bad++; end
    total++; if ({core_newKey, core_newData, core_readData, core_enc_dec} !== 4'b0) begin
      $display("FAIL reset_core_ctrl got=%b exp=0", {core_newKey, core_newData, core_readData, core_enc_dec}); bad++; end
    total++; if ({core_key, core_inData, rsp_data} !== '0) begin
      $display("FAIL reset_buses got=%h exp=0", {core_key, core_inData, rsp_data}); bad++; end
  endtask

  task automatic test_first();
    logic [1:0] rdy, rv; blk_t rd; int lat, nk, nd, nr; logic ok;
    do_block(0, 1'b1, 1'b0, P0, K0, 0, rdy, lat, rv, rd, nk, nd, nr, ok);
    first_lat = lat;
    total++; if (rdy !== 2'b01) begin $display("FAIL first_ready got=%b exp=01", rdy); bad++; end
    total++; if (rv !== 2'b01) begin $display("FAIL first_rsp_valid got=%b exp=01", rv); bad++; end
    total++; if (rd !== cipher(K0, P0, 1'b1)) begin
      $display("FAIL first_rsp_data got=%h exp=%h", rd, cipher(K0, P0, 1'b1)); bad++; end
    total++; if ({nk, nd, nr} !== {32'd1, 32'd1, 32'd1}) begin
      $display("FAIL first_pulses got=%0d/%0d/%0d exp=1/1/1", nk, nd, nr); bad++; end
    total++; if (lat !== 25) begin $display("FAIL first_latency got=%0d exp=25", lat); bad++; end
  endtask

  task automatic test_no_reload();
    logic [1:0] rdy, rv; blk_t rd; int lat, nk, nd, nr; logic ok;
    do_block(0, 1'b1, 1'b0, P1, K0, 0, rdy, lat, rv, rd, nk, nd, nr, ok);
    total++; if (nk !== 0) begin $display("FAIL noreload_newkey got=%0d exp=0", nk); bad++; end
    total++; if (lat !== first_lat - 2) begin
      $display("FAIL noreload_latency got=%0d exp=%0d", lat, first_lat - 2); bad++; end
    total++; if (rd !== cipher(K0, P1, 1'b1)) begin
      $display("FAIL noreload_data got=%h exp=%h", rd, cipher(K0, P1, 1'b1)); bad++; end
  endtask

  task automatic test_reload();
    logic [1:0] rdy, rv; blk_t rd; int lat, nk, nd, nr; logic ok;
    do_block(1, 1'b0, 1'b0, P2, K1, 0, rdy, lat, rv, rd, nk, nd, nr, ok);
    total++; if (rdy !== 2'b10) begin $display("FAIL reload1_ready got=%b exp=10", rdy); bad++; end
    total++; if (nk !== 1) begin $display("FAIL reload1_newkey got=%0d exp=1", nk); bad++; end
    total++; if (rv !== 2'b10 || rd !== cipher(K1, P2, 1'b0)) begin
      $display("FAIL reload1_rsp got=%b/%h exp=10/%h", rv, rd, cipher(K1, P2, 1'b0)); bad++; end
    do_block(0, 1'b1, 1'b0, P3, K0, 0, rdy, lat, rv, rd, nk, nd, nr, ok);
    total++; if (nk !== 1) begin $display("FAIL reload0_newkey got=%0d exp=1", nk); bad++; end
    total++; if (rd !== cipher(K0, P3, 1'b1)) begin
      $display("FAIL reload0_data got=%h exp=%h", rd, cipher(K0, P3, 1'b1)); bad++; end
  endtask

  task automatic test_hold();
    logic [1:0] rdy, rv; blk_t rd; int lat, nk, nd, nr; logic ok;
    do_block(0, 1'b1, 1'b0, P1, K0, 10, rdy, lat, rv, rd, nk, nd, nr, ok);
    total++; if (ok !== 1'b1) begin $display("FAIL hold_steady got=%b exp=1", ok); bad++; end
    total++; if (nr !== 1) begin $display("FAIL hold_readdata got=%0d exp=1", nr); bad++; end
    total++; if (busy !== 1'b0) begin $display("FAIL hold_idle got=%b exp=0", busy); bad++; end
  endtask

  task automatic test_alternate();
    logic [1:0] rdy; int lat;
    do_reset();
    req_valid = 2'b11; req_enc_dec = 2'b11; req_key_upd = 2'b00;
    req_data[0] = P2; req_key[0] = K0; req_data[1] = P3; req_key[1] = K1;
    #1 rdy = req_ready;
    total++; if (rdy !== 2'b01) begin $display("FAIL alt1_ready got=%b exp=01", rdy); bad++; end
    @(posedge clk); #1; req_valid[0] = 1'b0;
    wait_rsp(lat);
    total++; if (rsp_valid !== 2'b01 || rsp_data !== cipher(K0, P2, 1'b1)) begin
      $display("FAIL alt1_rsp got=%b/%h exp=01/%h", rsp_valid, rsp_data, cipher(K0, P2, 1'b1)); bad++; end
    ack(0);
    rdy = req_ready;
    total++; if (rdy !== 2'b10) begin $display("FAIL alt2_ready got=%b exp=10", rdy); bad++; end
    @(posedge clk); #1; req_valid[1] = 1'b0;
    wait_rsp(lat);
    total++; if (rsp_valid !== 2'b10 || rsp_data !== cipher(K1, P3, 1'b1)) begin
      $display("FAIL alt2_rsp got=%b/%h exp=10/%h", rsp_valid, rsp_data, cipher(K1, P3, 1'b1)); bad++; end
    ack(1);
    req_valid = 2'b11;
    #1 rdy = req_ready;
    total++; if (rdy !== 2'b01) begin $display("FAIL alt3_ready got=%b exp=01", rdy); bad++; end
    @(posedge clk); #1; req_valid = 2'b00;
    wait_rsp(lat);
    ack(0);
  endtask

  task automatic test_reset_mid();
    logic [1:0] rdy, rv; blk_t rd; int lat, nk, nd, nr; logic ok;
    req_valid[0] = 1'b1; req_enc_dec[0] = 1'b1; req_key_upd[0] = 1'b0;
    req_data[0] = P0; req_key[0] = K0;
    @(posedge clk); #1; req_valid[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1 nR = 1'b1;
    @(posedge clk); #1 nR = 1'b0;
    total++; if ({busy, rsp_valid, req_ready, owner} !== 6'b0) begin
      $display("FAIL midreset_state got=%b exp=0", {busy, rsp_valid, req_ready, owner}); bad++; end
    total++; if ({core_newKey, core_newData, core_readData, core_enc_dec, core_key, core_inData} !== '0) begin
      $display("FAIL midreset_core got=%h exp=0", {core_key, core_inData}); bad++; end
    do_block(0, 1'b1, 1'b0, P0, K0, 0, rdy, lat, rv, rd, nk, nd, nr, ok);
    total++; if (nk !== 1 || lat !== 25) begin
      $display("FAIL midreset_reload got=%0d/%0d exp=1/25", nk, lat); bad++; end
    total++; if (rd !== cipher(K0, P0, 1'b1)) begin
      $display("FAIL midreset_data got=%h exp=%h", rd, cipher(K0, P0, 1'b1)); bad++; end
  endtask

  initial begin
    nR = 1'b1; req_valid = '0; rsp_ready = '0; req_enc_dec = '0; req_key_upd = '0;
    req_data = '0; req_key = '0;
    test_reset();
    test_first();
    test_no_reload();
    test_reload();
    test_hold();
    test_alternate();
    test_reset_mid();
    total++; if (cnt_ovl !== 0) begin $display("FAIL pulse_overlap got=%0d exp=0", cnt_ovl); bad++; end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
